// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader turning RAM reads into a valid/ready stream with tlast
// Issue is throttled so in-flight reads plus buffered words never exceed the 4-entry FIFO.
module ram_stream_reader #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  localparam int   ADDR_W          = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [ADDR_W-1:0]    cmd_len,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic                 ram_regcea,
  output logic                 ram_rsta,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  output logic [RAM_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy,
  output logic                 done
);

  localparam int LAT = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]    beat_q, beat_d;
  logic [ADDR_W:0]      remain_q, remain_d;
  logic [LAT-1:0]       vld_sr_q, vld_sr_d;
  logic [RAM_WIDTH-1:0] fifo_q [4];
  logic [RAM_WIDTH-1:0] fifo_d [4];
  logic [1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]           count_q, count_d;

  logic [2:0] inflight;
  logic       issue, push, pop, last_beat;

  always_comb begin
    inflight  = 3'($countones(vld_sr_q));
    issue     = (state_q == RUN) && (({1'b0, inflight} + {1'b0, count_q}) < 4'd4);
    push      = vld_sr_q[LAT-1];
    pop       = (count_q != 3'd0) && m_tready;
    last_beat = (beat_q == len_q);

    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    remain_d = remain_q;
    beat_d   = pop ? beat_q + 1'b1 : beat_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          remain_d = {1'b0, cmd_len} + 1'b1;
          beat_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bit LAT-1 marks the cycle in which ram_douta carries a word we asked for.
    vld_sr_d = LAT'({vld_sr_q, issue});

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = ram_douta;
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      remain_q <= '0;
      vld_sr_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      remain_q <= remain_d;
      vld_sr_q <= vld_sr_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ram_ena    = issue;
  assign ram_addra  = addr_q;
  assign ram_wea    = 1'b0;
  assign ram_regcea = 1'b1;
  assign ram_rsta   = 1'b0;
  assign m_tvalid   = (count_q != 3'd0);
  assign m_tdata    = fifo_q[rd_ptr_q];
  assign m_tlast    = m_tvalid && last_beat;
  assign done       = pop && last_beat;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed bench driving a 2-cycle and a 1-cycle reader in lockstep
// Both readers share command/ready inputs and have their own behavioural RAM with mem[i]=i.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rsta_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       m_tready = 1'b0;

  logic        cmd_ready [2];
  logic [3:0]  ram_addra [2];
  logic        ram_ena [2];
  logic        ram_wea [2];
  logic        ram_regcea [2];
  logic        ram_rsta [2];
  logic [17:0] ram_douta [2];
  logic [17:0] m_tdata [2];
  logic        m_tvalid [2];
  logic        m_tlast [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(16), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_hp (
    .clka(clk), .rsta_n(rsta_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addra(ram_addra[0]), .ram_ena(ram_ena[0]),
    .ram_wea(ram_wea[0]), .ram_regcea(ram_regcea[0]), .ram_rsta(ram_rsta[0]),
    .ram_douta(ram_douta[0]), .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]),
    .m_tready(m_tready), .m_tlast(m_tlast[0]), .busy(busy[0]), .done(done[0]));

  ram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(16), .RAM_PERFORMANCE("LOW_LATENCY")) u_ll (
    .clka(clk), .rsta_n(rsta_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addra(ram_addra[1]), .ram_ena(ram_ena[1]),
    .ram_wea(ram_wea[1]), .ram_regcea(ram_regcea[1]), .ram_rsta(ram_rsta[1]),
    .ram_douta(ram_douta[1]), .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]),
    .m_tready(m_tready), .m_tlast(m_tlast[1]), .busy(busy[1]), .done(done[1]));

  logic [17:0] mem [16];
  logic [17:0] q1 [2];
  logic [17:0] q2_hp;

  always @(posedge clk) begin
    if (ram_ena[0]) q1[0] <= mem[ram_addra[0]];
    if (ram_ena[1]) q1[1] <= mem[ram_addra[1]];
    if (ram_regcea[0]) q2_hp <= q1[0];
  end
  assign ram_douta[0] = q2_hp;
  assign ram_douta[1] = q1[1];

  int          nq [2], ena_cnt [2], done_cnt [2], hs_cyc [2], outst [2];
  int          bad_stall [2], bad_done [2], bad_rdy [2], bad_out [2];
  bit          pend_rdy [2], prev_stall [2];
  logic [17:0] prev_data [2];
  logic        prev_last [2];
  logic [17:0] wdat [2][128];
  logic        wlast [2][128];
  int          wcyc [2][128];
  int          ecyc [2][128];
  logic [3:0]  aq [2][128];
  logic        mon_hsk;

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rsta_n) begin
        outst[d] = 0;
        prev_stall[d] = 1'b0;
        pend_rdy[d] = 1'b0;
      end else begin
        if (pend_rdy[d] && !(cmd_ready[d] && !busy[d])) bad_rdy[d]++;
        pend_rdy[d] = 1'b0;
        if (cmd_valid && cmd_ready[d]) hs_cyc[d] = cyc;
        if (prev_stall[d] && !(m_tvalid[d] && m_tdata[d] === prev_data[d] && m_tlast[d] === prev_last[d]))
          bad_stall[d]++;
        if (ram_ena[d]) begin
          aq[d][ena_cnt[d] % 128] = ram_addra[d];
          ecyc[d][ena_cnt[d] % 128] = cyc;
          ena_cnt[d]++;
          outst[d]++;
        end
        mon_hsk = m_tvalid[d] && m_tready;
        if (done[d] !== (mon_hsk && m_tlast[d])) bad_done[d]++;
        if (done[d]) begin
          done_cnt[d]++;
          pend_rdy[d] = 1'b1;
          if (cmd_ready[d]) bad_rdy[d]++;
        end
        if (mon_hsk) begin
          wdat[d][nq[d] % 128] = m_tdata[d];
          wlast[d][nq[d] % 128] = m_tlast[d];
          wcyc[d][nq[d] % 128] = cyc;
          nq[d]++;
          outst[d]--;
        end
        if (outst[d] > 4) bad_out[d]++;
        prev_stall[d] = m_tvalid[d] && !m_tready;
        prev_data[d] = m_tdata[d];
        prev_last[d] = m_tlast[d];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int bn [2], be [2], bd [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s_%0d", tag, d),
            64'({cmd_ready[d], ram_ena[d], ram_addra[d], ram_wea[d], ram_regcea[d], ram_rsta[d],
                 m_tvalid[d], m_tlast[d], m_tdata[d], busy[d], done[d]}),
            64'({1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0}));
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,0,1; 2: ready low for 20 cycles then high
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] l, input int mode);
    int   need;
    logic finished;
    need = int'(l) + 1;
    for (int d = 0; d < 2; d++) begin
      bn[d] = nq[d];
      be[d] = ena_cnt[d];
      bd[d] = done_cnt[d];
    end
    m_tready = (mode != 2);
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 300 && !finished; i++) begin
      case (mode)
        1:       m_tready = (i % 5 == 0) || (i % 5 == 4);
        2:       m_tready = (i >= 20);
        default: m_tready = 1'b1;
      endcase
      if (mode == 2 && i == 20) begin
        for (int d = 0; d < 2; d++) begin
          check($sformatf("stall_ena_%0d", d), 64'(ena_cnt[d] - be[d]), 64'd4);
          check($sformatf("stall_words_%0d", d), 64'(nq[d] - bn[d]), 64'd0);
        end
      end
      @(posedge clk);
      #1;
      finished = (nq[0] - bn[0] >= need) && (nq[1] - bn[1] >= need) && !busy[0] && !busy[1];
    end
    check("burst_complete", 64'(finished), 64'd1);
  endtask

  task automatic check_words(input string tag, input logic [3:0] a, input logic [3:0] l, input bit timing);
    int n;
    n = int'(l) + 1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_count_%0d", tag, d), 64'(nq[d] - bn[d]), 64'(n));
      check($sformatf("%s_done_%0d", tag, d), 64'(done_cnt[d] - bd[d]), 64'd1);
      check($sformatf("%s_issues_%0d", tag, d), 64'(ena_cnt[d] - be[d]), 64'(n));
      if (timing) begin
        check($sformatf("%s_latency_%0d", tag, d), 64'(wcyc[d][bn[d] % 128] - hs_cyc[d]),
              64'((d == 0) ? 4 : 3));
      end
      for (int k = 0; k < n; k++) begin
        check($sformatf("%s_data_%0d_%0d", tag, d, k), 64'(wdat[d][(bn[d] + k) % 128]),
              64'((int'(a) + k) % 16));
        check($sformatf("%s_last_%0d_%0d", tag, d, k), 64'(wlast[d][(bn[d] + k) % 128]),
              64'(k == n - 1));
        check($sformatf("%s_addr_%0d_%0d", tag, d, k), 64'(aq[d][(be[d] + k) % 128]),
              64'((int'(a) + k) % 16));
        if (timing) begin
          check($sformatf("%s_ena_cyc_%0d_%0d", tag, d, k), 64'(ecyc[d][(be[d] + k) % 128] - hs_cyc[d]),
                64'(1 + k));
          check($sformatf("%s_beat_cyc_%0d_%0d", tag, d, k),
                64'(wcyc[d][(bn[d] + k) % 128] - wcyc[d][bn[d] % 128]), 64'(k));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 18'(i);
    q1[0] = '0;
    q1[1] = '0;
    q2_hp = '0;

    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    #3 rsta_n = 1'b1;
    @(posedge clk);
    #1 check_reset("idle_after_reset");

    run_cmd(4'd5, 4'd3, 0);
    check_words("basic", 4'd5, 4'd3, 1'b1);

    run_cmd(4'd14, 4'd3, 0);
    check_words("wrap", 4'd14, 4'd3, 1'b1);

    run_cmd(4'd2, 4'd9, 1);
    check_words("backpressure", 4'd2, 4'd9, 1'b0);

    run_cmd(4'd3, 4'd7, 2);
    check_words("full_stall", 4'd3, 4'd7, 1'b0);

    begin : mid_reset
      logic reached;
      for (int d = 0; d < 2; d++) bn[d] = nq[d];
      m_tready = 1'b1;
      cmd_addr = 4'd0;
      cmd_len = 4'd15;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
        @(posedge clk);
        #1 reached = (nq[0] - bn[0] >= 3);
      end
      check("mid_reset_reached", 64'(reached), 64'd1);
      #2 rsta_n = 1'b0;
      #1 check_reset("mid_reset_async");
      repeat (2) @(posedge clk);
      #3 rsta_n = 1'b1;
      @(posedge clk);
      #1 check_reset("mid_reset_release");
    end

    run_cmd(4'd0, 4'd1, 0);
    check_words("after_reset", 4'd0, 4'd1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("after_reset_no_extra_%0d", d), 64'(nq[d] - bn[d]), 64'd2);
      check($sformatf("stall_stability_%0d", d), 64'(bad_stall[d]), 64'd0);
      check($sformatf("done_alignment_%0d", d), 64'(bad_done[d]), 64'd0);
      check($sformatf("ready_after_done_%0d", d), 64'(bad_rdy[d]), 64'd0);
      check($sformatf("outstanding_limit_%0d", d), 64'(bad_out[d]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the single-port RAM block; never writes.
- Accepts a burst command (start address, word count), issues RAM reads and presents the words as a valid/ready stream with tlast.
- Handles the RAM's fixed 1- or 2-cycle read latency and downstream backpressure with an internal 4-entry credit FIFO.
- Sits between a RAM instance and stream consumers (DMA, packetizers).

Parameters:
- RAM_WIDTH, 18, data width; must match the attached RAM.
- RAM_DEPTH, 1024, number of RAM entries; ADDR_W = clogb2(RAM_DEPTH-1).
- RAM_PERFORMANCE, "HIGH_PERFORMANCE", "HIGH_PERFORMANCE" gives read latency L=2; "LOW_LATENCY" gives L=1; must match the RAM.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- rsta_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W  word count minus 1 (0 means 1 word).
- ram_addra  out  ADDR_W  RAM address.
- ram_ena  out  1  RAM enable; high exactly on read-issue cycles.
- ram_wea  out  1  constant 0.
- ram_regcea  out  1  constant 1 (output register always advances).
- ram_rsta  out  1  constant 0.
- ram_douta  in  RAM_WIDTH  RAM read data.
- m_tdata  out  RAM_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final word of the burst.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse on the cycle the last word handshakes.

Behaviour:
- Reset (async assert, sync release) forces state IDLE and clears the FIFO, in-flight shift register, counters and outputs:
  - cmd_ready=1 after reset; ram_ena=0; ram_addra=0.
  - m_tvalid=0; m_tlast=0; m_tdata=0; busy=0; done=0.
- FSM states and transitions:
  - IDLE: cmd_valid && cmd_ready latches addr and remaining=cmd_len+1, then goes to RUN.
  - RUN: issues one read per cycle while (inflight + fifo_count) < 4. inflight is the number of valid bits in an L-deep shift register. After the last issue, goes to DRAIN.
  - DRAIN: issues nothing. Goes to IDLE on the handshake of the word with m_tlast.
  - Commands are never accepted outside IDLE.
- Issue cycle: ram_ena=1 and ram_addra=current address. The address then increments modulo RAM_DEPTH, wrapping from RAM_DEPTH-1 to 0 (also for non-power-of-2 depths). The in-flight shift register is loaded with 1.
- Returning data:
  - The shift-register output marks the cycle in which ram_douta is valid; that word is written into the FIFO at the clock edge ending that cycle.
  - The FIFO is registered, first-word-through on its output: m_tvalid = fifo not empty.
- Latency: command handshake in cycle 0, first ram_ena in cycle 1, first m_tvalid in cycle 2+L (4 for HIGH_PERFORMANCE, 3 for LOW_LATENCY).
- Throughput: with m_tready held high, one word per cycle sustained and no issue bubbles for both L values.
- Backpressure: with m_tready=0, m_tdata, m_tvalid and m_tlast hold stable. Issue stops once inflight + count = 4, so the FIFO never overflows and no returning word is lost.
- FIFO boundaries: push and pop in the same cycle leave count unchanged. A pop when empty is impossible because m_tvalid=0.
- m_tlast is high exactly for word number cmd_len+1. It is tracked by a beat counter on the output side.
- done pulses together with the final handshake. cmd_ready rises on the next cycle, so back-to-back commands have one idle cycle.
- cmd_len = RAM_DEPTH-1 reads the whole RAM once, including wrap when cmd_addr≠0.
- Reset mid-burst: all state is cleared immediately. In-flight RAM data that arrives after reset is ignored because the valid shift register was cleared. The next command starts clean.

Test Plan:
- Reset then command addr=5, len=3, RAM preloaded mem[i]=i, m_tready=1, HIGH_PERFORMANCE -> m_tvalid rises in cycle 4; words 5,6,7,8 on consecutive cycles; tlast and done on word 8; then cmd_ready=1.
- Same command with LOW_LATENCY -> first word in cycle 3; 4 consecutive words.
- Wrap: RAM_DEPTH=16, addr=14, len=3 -> stream 14,15,0,1; ram_addra shows the wrap; tlast on 1.
- Backpressure: len=9, m_tready toggles 1,0,0,0,1 repeatedly -> all 10 words in order, no duplicates or drops; data stable while stalled; inflight + count never exceeds 4.
- Full stall: len=7, m_tready=0 for 20 cycles then 1 -> exactly 4 ram_ena pulses during the stall; then the remaining 4 issued; 8 words delivered in order.
- Reset mid-burst: assert rsta_n=0 after 3 words of len=15 -> all outputs at reset values asynchronously. A new command addr=0, len=1 returns exactly mem[0], mem[1] with tlast on the second word.
